// File: rtl/riscv_pkg.sv
// Shared core types: multiply/divide op encoding and divide sequencer state/constants.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [2:0] {
        MD_OP_MUL,
        MD_OP_MULH,
        MD_OP_MULHSU,
        MD_OP_MULHU,
        MD_OP_DIV,
        MD_OP_DIVU,
        MD_OP_REM,
        MD_OP_REMU
    } mult_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_e;

    localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] DIV_OVF_Q  = 32'h8000_0000;

endpackage

// File: rtl/div_seq_ctrl.sv
// EX-stage multicycle divide sequencer: 32-step radix-2 restoring divide with held result.
module div_seq_ctrl
    import riscv_pkg::*;
#(
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            div_valid_i,
    input  mult_op_e        div_op_i,
    input  logic [31:0]     op_a_i,
    input  logic [31:0]     op_b_i,
    input  logic            kill_i,
    input  logic            out_ready_i,
    output logic            busy_o,
    output logic            result_valid_o,
    output logic [31:0]     result_o
);

    localparam int unsigned W  = XLEN;
    localparam int unsigned CW = 5;

    div_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W:0]     rem_q, rem_d;
    logic [W-1:0]   quo_q, quo_d;
    logic [W-1:0]   b_abs_q, b_abs_d;
    logic           is_rem_q, is_rem_d;
    logic           neg_q_q, neg_q_d;
    logic           neg_r_q, neg_r_d;
    logic           busy_d, valid_d;
    logic [W-1:0]   result_d;

    // Operand decode for the accept cycle
    logic           is_signed_c, is_rem_c, a_neg_c, b_neg_c, b_zero_c, ovf_c;
    logic [W-1:0]   a_abs_c, b_abs_c, special_res_c;

    always_comb begin
        is_signed_c   = (div_op_i == MD_OP_DIV) || (div_op_i == MD_OP_REM);
        is_rem_c      = (div_op_i == MD_OP_REM) || (div_op_i == MD_OP_REMU);
        a_neg_c       = is_signed_c & op_a_i[W-1];
        b_neg_c       = is_signed_c & op_b_i[W-1];
        a_abs_c       = a_neg_c ? W'(-op_a_i) : op_a_i;
        b_abs_c       = b_neg_c ? W'(-op_b_i) : op_b_i;
        b_zero_c      = (op_b_i == '0);
        ovf_c         = is_signed_c && (op_a_i == DIV_OVF_Q) && (op_b_i == DIV_ZERO_Q);
        special_res_c = b_zero_c ? (is_rem_c ? op_a_i : DIV_ZERO_Q)
                                 : (is_rem_c ? '0 : DIV_OVF_Q);
    end

    // One restoring step plus the sign-fixed result it would produce
    logic [W+1:0]   shifted_c;
    logic           fits_c;
    logic [W:0]     step_rem_c;
    logic [W-1:0]   step_quo_c, q_fix_c, r_fix_c;

    always_comb begin
        shifted_c  = {rem_q, quo_q[W-1]};
        fits_c     = shifted_c >= (W+2)'(b_abs_q);
        step_rem_c = fits_c ? (W+1)'(shifted_c - (W+2)'(b_abs_q)) : (W+1)'(shifted_c);
        step_quo_c = {quo_q[W-2:0], fits_c};
        q_fix_c    = neg_q_q ? W'(-step_quo_c) : step_quo_c;
        r_fix_c    = neg_r_q ? W'(-W'(step_rem_c)) : W'(step_rem_c);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        b_abs_d  = b_abs_q;
        is_rem_d = is_rem_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        busy_d   = busy_o;
        valid_d  = result_valid_o;
        result_d = result_o;

        if (kill_i) begin
            state_d = DIV_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (div_valid_i) begin
                        busy_d   = 1'b1;
                        is_rem_d = is_rem_c;
                        // Quotient sign fix is suppressed for b==0 so the all-ones pattern survives
                        neg_q_d  = is_signed_c & (op_a_i[W-1] ^ op_b_i[W-1]) & ~b_zero_c;
                        neg_r_d  = a_neg_c;
                        b_abs_d  = b_abs_c;
                        if (FAST_SPECIAL && (b_zero_c || ovf_c)) begin
                            state_d  = DIV_DONE;
                            valid_d  = 1'b1;
                            result_d = special_res_c;
                        end else begin
                            state_d = DIV_CALC;
                            cnt_d   = CW'(W - 1);
                            rem_d   = '0;
                            quo_d   = a_abs_c;
                        end
                    end
                end
                DIV_CALC: begin
                    rem_d = step_rem_c;
                    quo_d = step_quo_c;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d  = DIV_DONE;
                        valid_d  = 1'b1;
                        result_d = is_rem_q ? r_fix_c : q_fix_c;
                    end
                end
                DIV_DONE: begin
                    if (out_ready_i) begin
                        state_d = DIV_IDLE;
                        busy_d  = 1'b0;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = DIV_IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= DIV_IDLE;
            cnt_q          <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            b_abs_q        <= '0;
            is_rem_q       <= 1'b0;
            neg_q_q        <= 1'b0;
            neg_r_q        <= 1'b0;
            busy_o         <= 1'b0;
            result_valid_o <= 1'b0;
            result_o       <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rem_q          <= rem_d;
            quo_q          <= quo_d;
            b_abs_q        <= b_abs_d;
            is_rem_q       <= is_rem_d;
            neg_q_q        <= neg_q_d;
            neg_r_q        <= neg_r_d;
            busy_o         <= busy_d;
            result_valid_o <= valid_d;
            result_o       <= result_d;
        end
    end

endmodule
